// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the mux2 control-channel arbiter.
//   state_e      : handshake FSM states (idle, setup, request, return-to-zero)
//   DefaultBurst : default max consecutive grants to one channel under contention
//   DefaultCntW  : default width of the per-channel grant counters
//   arb_pick     : grant decision for the current pending requests and run history
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StReq   = 2'd2,
    StRtz   = 2'd3
  } state_e;

  localparam int unsigned DefaultBurst = 4;
  localparam int unsigned DefaultCntW  = 16;
  // Holds burst limits up to 15.
  localparam int unsigned BurstCntW    = 4;

  // Caller guarantees at least one request is pending.
  function automatic logic arb_pick(input logic                 req0,
                                    input logic                 req1,
                                    input logic                 last,
                                    input logic [BurstCntW-1:0] burst_cnt,
                                    input logic [BurstCntW-1:0] burst_lim);
    logic pick;
    if (req0 && !req1) begin
      pick = 1'b0;
    end else if (req1 && !req0) begin
      pick = 1'b1;
    end else if (burst_cnt != '0 && burst_cnt < burst_lim) begin
      pick = last;
    end else begin
      // burst_cnt is zero only before the first grant; last resets to 1, so the
      // first tie lands on channel 0.
      pick = ~last;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux2_arb_sync2.sv
// Two-flop synchronizer for one asynchronous input bit.
//   clk : destination clock
//   rst : asynchronous active-low reset, clears both stages
//   d_i : asynchronous input
//   q_o : input resynchronized to clk (two cycles of latency)
module mux2_arb_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mux2_arb.sv
// Two-channel arbiter driving the control channel of a sequenced mux2 with a
// 4-phase handshake (rctl up, actl up, rctl down, actl down). Under contention a
// channel keeps the grant for at most BURST consecutive handshakes.
//
// Build option: define MUX2_ARB_SYNC_EN to pass req0_i, req1_i and actl_i through
// two-flop synchronizers (two extra cycles per input-dependent step). Without it
// the inputs must be synchronous to clk.
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst    : asynchronous active-low reset
//   req0_i : channel-0 request
//   req1_i : channel-1 request
//   rctl_o : control-channel request to mux2
//   dctl_o : control-channel select to mux2 (0 = channel 0, 1 = channel 1)
//   actl_i : control-channel acknowledge from mux2
//   busy_o : high while a handshake is in progress (state not idle)
//   cnt0_o : completed channel-0 grants, wraps
//   cnt1_o : completed channel-1 grants, wraps
module mux2_arb
  import mux2_arb_pkg::*;
#(
  parameter int unsigned BURST = DefaultBurst,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_i,
  input  logic             req1_i,
  output logic             rctl_o,
  output logic             dctl_o,
  input  logic             actl_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt0_o,
  output logic [CNT_W-1:0] cnt1_o
);

  localparam logic [BurstCntW-1:0] BurstLim = BurstCntW'(BURST);

  logic req0;
  logic req1;
  logic actl;

`ifdef MUX2_ARB_SYNC_EN
  mux2_arb_sync2 u_sync_req0 (
    .clk (clk),
    .rst (rst),
    .d_i (req0_i),
    .q_o (req0)
  );

  mux2_arb_sync2 u_sync_req1 (
    .clk (clk),
    .rst (rst),
    .d_i (req1_i),
    .q_o (req1)
  );

  mux2_arb_sync2 u_sync_actl (
    .clk (clk),
    .rst (rst),
    .d_i (actl_i),
    .q_o (actl)
  );
`else
  assign req0 = req0_i;
  assign req1 = req1_i;
  assign actl = actl_i;
`endif

  state_e               state_q;
  logic                 rctl_q;
  logic                 dctl_q;
  logic                 busy_q;
  logic                 last_q;
  logic [BurstCntW-1:0] burst_cnt_q;
  logic [CNT_W-1:0]     cnt0_q;
  logic [CNT_W-1:0]     cnt1_q;
  logic                 grant;

  assign grant = arb_pick(req0, req1, last_q, burst_cnt_q, BurstLim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rctl_q      <= 1'b0;
      dctl_q      <= 1'b0;
      busy_q      <= 1'b0;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // A high actl here is a stale ack from a previous cycle; wait it out.
          if (!actl && (req0 || req1)) begin
            dctl_q  <= grant;
            last_q  <= grant;
            busy_q  <= 1'b1;
            state_q <= StSetup;
            if (grant != last_q || burst_cnt_q == '0) begin
              burst_cnt_q <= BurstCntW'(1);
            end else if (burst_cnt_q < BurstLim) begin
              burst_cnt_q <= burst_cnt_q + BurstCntW'(1);
            end
          end
        end
        StSetup: begin
          // One cycle of dctl setup before rctl rises (bundled data).
          rctl_q  <= 1'b1;
          state_q <= StReq;
        end
        StReq: begin
          if (actl) begin
            rctl_q  <= 1'b0;
            state_q <= StRtz;
          end
        end
        StRtz: begin
          if (!actl) begin
            if (dctl_q) begin
              cnt1_q <= cnt1_q + CNT_W'(1);
            end else begin
              cnt0_q <= cnt0_q + CNT_W'(1);
            end
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          rctl_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rctl_o = rctl_q;
  assign dctl_o = dctl_q;
  assign busy_o = busy_q;
  assign cnt0_o = cnt0_q;
  assign cnt1_o = cnt1_q;

endmodule

// File: tb/tb_mux2_arb.sv
// Scoreboard bench for mux2_arb. Instance 0: BURST=4, CNT_W=4. Instance 1: BURST=1,
// CNT_W=16. Expected grants come from a history-based arbitration model.
module tb_mux2_arb;

`ifdef MUX2_ARB_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif
  localparam int BurstA = 4;
  localparam int BurstB = 1;

  logic clk = 1'b0;
  logic rst;
  logic req0 [2];
  logic req1 [2];
  logic actl [2];
  logic rctl [2];
  logic dctl [2];
  logic busy [2];
  logic [3:0]  cnt0_a, cnt1_a;
  logic [15:0] cnt0_b, cnt1_b;

  always #5 clk = ~clk;

  mux2_arb #(.BURST(BurstA), .CNT_W(4)) u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .req0_i (req0[0]),
    .req1_i (req1[0]),
    .rctl_o (rctl[0]),
    .dctl_o (dctl[0]),
    .actl_i (actl[0]),
    .busy_o (busy[0]),
    .cnt0_o (cnt0_a),
    .cnt1_o (cnt1_a)
  );

  mux2_arb #(.BURST(BurstB), .CNT_W(16)) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .req0_i (req0[1]),
    .req1_i (req1[1]),
    .rctl_o (rctl[1]),
    .dctl_o (dctl[1]),
    .actl_i (actl[1]),
    .busy_o (busy[1]),
    .cnt0_o (cnt0_b),
    .cnt1_o (cnt1_b)
  );

  int checks = 0;
  int errors = 0;

  // Model and scoreboard state.
  int hist0[$], hist1[$];
  int expq0[$], expq1[$];
  int glog0[$], glog1[$];
  int exp_c0 [2];
  int exp_c1 [2];
  int cur_g [2];
  int done_cnt [2];
  logic rctl_p [2];
  logic busy_p [2];
  bit resp_en [2];
  bit resp_rand;

  int ord4 [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int ord1 [6]  = '{0, 1, 0, 1, 0, 1};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int d, input int ch);
    if (d == 0) return (ch == 0) ? int'(cnt0_a) : int'(cnt1_a);
    return (ch == 0) ? int'(cnt0_b) : int'(cnt1_b);
  endfunction

  // Grant rule from the run history: single request wins; on a tie the last
  // channel keeps it while its trailing run is shorter than the burst limit.
  function automatic void model_push(input int d, input bit r0, input bit r1);
    int g, run, last, lim, n, h;
    lim = (d == 0) ? BurstA : BurstB;
    n = (d == 0) ? hist0.size() : hist1.size();
    if (r0 && !r1) g = 0;
    else if (r1 && !r0) g = 1;
    else if (n == 0) g = 0;
    else begin
      last = (d == 0) ? hist0[n-1] : hist1[n-1];
      run = 0;
      for (int i = n - 1; i >= 0; i--) begin
        h = (d == 0) ? hist0[i] : hist1[i];
        if (h != last) break;
        run++;
      end
      g = (run < lim) ? last : 1 - last;
    end
    if (d == 0) begin
      hist0.push_back(g);
      expq0.push_back(g);
    end else begin
      hist1.push_back(g);
      expq1.push_back(g);
    end
  endfunction

  function automatic void model_clear();
    hist0.delete(); hist1.delete();
    expq0.delete(); expq1.delete();
    glog0.delete(); glog1.delete();
    for (int d = 0; d < 2; d++) begin
      exp_c0[d] = 0;
      exp_c1[d] = 0;
      cur_g[d]  = 0;
    end
  endfunction

  // Monitor: pops an expected grant on each rctl rise, checks counters on completion.
  initial begin
    int g, mask;
    for (int d = 0; d < 2; d++) begin
      rctl_p[d] = 1'b0;
      busy_p[d] = 1'b0;
      done_cnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        mask = (d == 0) ? 32'hf : 32'hffff;
        if (rst) begin
          if (rctl[d] && !rctl_p[d]) begin
            if (((d == 0) ? expq0.size() : expq1.size()) == 0) begin
              checks++;
              errors++;
              $display("FAIL grant_unexpected: dut %0d sel %0d, expected no grant", d,
                       dctl[d]);
            end else begin
              if (d == 0) g = expq0.pop_front();
              else g = expq1.pop_front();
              check($sformatf("grant_sel_dut%0d", d), int'(dctl[d]), g);
              cur_g[d] = g;
              if (d == 0) glog0.push_back(int'(dctl[d]));
              else glog1.push_back(int'(dctl[d]));
            end
          end
          if (!busy[d] && busy_p[d]) begin
            done_cnt[d]++;
            if (cur_g[d] == 1) exp_c1[d] = (exp_c1[d] + 1) & mask;
            else exp_c0[d] = (exp_c0[d] + 1) & mask;
            check($sformatf("cnt0_dut%0d", d), cnt_of(d, 0), exp_c0[d]);
            check($sformatf("cnt1_dut%0d", d), cnt_of(d, 1), exp_c1[d]);
          end
        end
        rctl_p[d] = rctl[d];
        busy_p[d] = busy[d];
      end
    end
  end

  // Responder: mux2 stand-in echoing rctl onto actl, randomly delayed.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (resp_en[d] && actl[d] !== rctl[d] && (!resp_rand || $urandom_range(0, 2) != 0))
          actl[d] = rctl[d];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input int d, input logic val);
    int n = 0;
    while (busy[d] !== val && n < 200) begin
      tick();
      n++;
    end
    if (busy[d] !== val) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: dut %0d busy %0d, expected %0d", d, busy[d], val);
    end
  endtask

  task automatic wait_done(input int d, input int target);
    int n = 0;
    while (done_cnt[d] < target && n < 400) begin
      tick();
      n++;
    end
    if (done_cnt[d] < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: dut %0d completions %0d, expected %0d", d, done_cnt[d],
               target);
    end
  endtask

  task automatic run_txn(input int d, input bit r0, input bit r1);
    int start = done_cnt[d];
    model_push(d, r0, r1);
    req0[d] = r0;
    req1[d] = r1;
    wait_busy(d, 1'b1);
    req0[d] = 1'b0;
    req1[d] = 1'b0;
    wait_done(d, start + 1);
  endtask

  task automatic burst_run(input int d, input int n);
    int start = done_cnt[d];
    for (int i = 0; i < n; i++) model_push(d, 1'b1, 1'b1);
    req0[d] = 1'b1;
    req1[d] = 1'b1;
    wait_done(d, start + n - 1);
    wait_busy(d, 1'b1);
    req0[d] = 1'b0;
    req1[d] = 1'b0;
    wait_done(d, start + n);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int n, p, start;
    rst = 1'b0;
    resp_rand = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req0[d] = 1'b0;
      req1[d] = 1'b0;
      actl[d] = 1'b0;
      resp_en[d] = 1'b1;
    end
    model_clear();
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check("reset_rctl", int'(rctl[d]), 0);
      check("reset_dctl", int'(dctl[d]), 0);
      check("reset_busy", int'(busy[d]), 0);
      check("reset_cnt0", cnt_of(d, 0), 0);
      check("reset_cnt1", cnt_of(d, 1), 0);
    end
    rst = 1'b1;
    tick();

    // First-transaction latency with a one-cycle echo responder.
    resp_rand = 1'b0;
    model_push(0, 1'b1, 1'b0);
    req0[0] = 1'b1;
    tick();
    repeat (SyncLat) tick();
    check("latency_setup_busy", int'(busy[0]), 1);
    check("latency_setup_rctl", int'(rctl[0]), 0);
    tick();
    check("latency_rctl_up", int'(rctl[0]), 1);
    check("latency_dctl", int'(dctl[0]), 0);
    req0[0] = 1'b0;
    wait_done(0, 1);
    check("latency_cnt0", int'(cnt0_a), 1);
    resp_rand = 1'b1;

    // BURST=4 contention order.
    do_reset();
    burst_run(0, 12);
    check("burst4_len", glog0.size(), 12);
    for (int i = 0; i < 12 && i < glog0.size(); i++) check("burst4_order", glog0[i], ord4[i]);
    check("burst4_cnt0", int'(cnt0_a), 8);
    check("burst4_cnt1", int'(cnt1_a), 4);

    // BURST=1 strict alternation.
    do_reset();
    burst_run(1, 6);
    check("burst1_len", glog1.size(), 6);
    for (int i = 0; i < 6 && i < glog1.size(); i++) check("burst1_order", glog1[i], ord1[i]);

    // Counter wrap at CNT_W=4.
    do_reset();
    for (int i = 0; i < 17; i++) run_txn(0, 1'b0, 1'b1);
    check("wrap_cnt1", int'(cnt1_a), 1);
    check("wrap_cnt0", int'(cnt0_a), 0);

    // Stale ack held across reset release.
    resp_en[0] = 1'b0;
    actl[0] = 1'b1;
    rst = 1'b0;
    model_clear();
    req1[0] = 1'b1;
    tick();
    rst = 1'b1;
    repeat (6) tick();
    check("stale_ack_busy", int'(busy[0]), 0);
    check("stale_ack_rctl", int'(rctl[0]), 0);
    start = done_cnt[0];
    model_push(0, 1'b0, 1'b1);
    actl[0] = 1'b0;
    resp_en[0] = 1'b1;
    wait_busy(0, 1'b1);
    req1[0] = 1'b0;
    wait_done(0, start + 1);
    check("stale_ack_grant", (glog0.size() > 0) ? glog0[0] : -1, 1);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 25; i++) begin
        p = $urandom_range(1, 3);
        if ($urandom_range(0, 2) == 0) begin
          n = $urandom_range(2, 7);
          burst_run(d, n);
        end else begin
          run_txn(d, p[0], p[1]);
        end
      end
    end

    // Reset while waiting in the request phase.
    resp_en[0] = 1'b0;
    model_push(0, 1'b1, 1'b0);
    req0[0] = 1'b1;
    n = 0;
    while (rctl[0] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("midreq_rctl_up", int'(rctl[0]), 1);
    req0[0] = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreq_rctl_drop", int'(rctl[0]), 0);
    check("midreq_busy", int'(busy[0]), 0);
    check("midreq_dctl", int'(dctl[0]), 0);
    check("midreq_cnt0", int'(cnt0_a), 0);
    check("midreq_cnt1", int'(cnt1_a), 0);
    model_clear();
    tick();
    rst = 1'b1;
    resp_en[0] = 1'b1;
    tick();

    // First tie after reset goes to channel 0.
    run_txn(0, 1'b1, 1'b1);
    check("first_tie", (glog0.size() > 0) ? glog0[0] : -1, 0);

    check("queue0_drained", expq0.size(), 0);
    check("queue1_drained", expq1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
